net_tx_arbiter: RTL and testbench

- Round-robin arbiter sharing one GPU's 16-bit network egress port between N_REQ local requesters (packet generator, AXI master completion notifier, slave error reporter, etc.).
- Flit format {dest[5:0], payload[9:0]}.
- Grants whole multi-flit messages with a burst limit and an idle timeout, then drives the NI through a registered output stage.
- Flits addressed to the GPU's own ID are discarded and counted.

---
 rtl/net_pkg.sv | 31 +++
 rtl/rr_pick.sv | 45 ++++
 rtl/net_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_net_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : net_pkg
//  Description : Shared definitions for the network egress path: flit
//                geometry, dest/payload field positions, arbiter state
//                encoding and a dest-field extraction helper.
//  Revision    : 1.0  initial release
// ============================================================================
package net_pkg;

    localparam int NET_FLIT_W   = 16;
    localparam int NET_DEST_W   = 6;
    localparam int NET_PAY_W    = 10;

    // Flit layout: {dest[5:0], payload[9:0]}
    localparam int NET_DEST_MSB = 15;
    localparam int NET_DEST_LSB = 10;
    localparam int NET_PAY_MSB  = 9;
    localparam int NET_PAY_LSB  = 0;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NET_DEST_W-1:0] flit_dest(input logic [NET_FLIT_W-1:0] flit);
        return flit[NET_DEST_MSB:NET_DEST_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational cyclic priority search. Returns the first
//                asserted request at or after ptr, wrapping past N-1 to 0.
//  Revision    : 1.0  initial release
//  Ports       : req      in  N   request vector
//                ptr      in  IW  search start position (must be < N)
//                gnt      out N   one-hot winner (all zero when no request)
//                idx      out IW  index of the winner
//                any_req  out 1   at least one request is asserted
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    always_comb begin : p_pick
        int pos;
        pos     = 0;
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            // Walk ptr, ptr+1, ... wrapping; first hit wins.
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any_req && req[pos]) begin
                any_req  = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/net_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : net_tx_arbiter
//  Description : Round-robin arbiter sharing the 16-bit network egress port
//                between N_REQ requesters. Grants whole messages, bounded by
//                a burst limit and an idle timeout; drops and counts flits
//                addressed to this GPU; registered output stage to the NI.
//  Revision    : 1.0  initial release
//  Ports       : ACLK           in   clock, rising edge
//                ARESET         in   asynchronous active-high reset
//                req_valid      in   N_REQ    per-requester flit valid
//                req_data       in   16*N_REQ requester k at [16k+15:16k]
//                req_last       in   N_REQ    last flit of message
//                req_ready      out  N_REQ    flit accepted when valid&ready
//                net_data_out   out  16       flit to NI
//                net_valid_out  out  1        flit valid to NI
//                net_ready_in   in   1        NI accepts flit
//                grant_id       out  clog2(N_REQ) current/last grant
//                busy           out  1        arbiter is in GRANT
//                self_drop_cnt  out  8        saturating self-flit drop count
// ============================================================================
module net_tx_arbiter
    import net_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int GPU_ID       = 16,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [NET_FLIT_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    output logic [NET_FLIT_W-1:0]         net_data_out,
    output logic                          net_valid_out,
    input  logic                          net_ready_in,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy,
    output logic [7:0]                    self_drop_cnt
);

    localparam int                    IDW            = $clog2(N_REQ);
    localparam logic [NET_DEST_W-1:0] c_self_id      = NET_DEST_W'(GPU_ID);
    localparam logic [4:0]            c_max_burst    = 5'(MAX_BURST);
    localparam logic [8:0]            c_idle_timeout = 9'(IDLE_TIMEOUT);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [IDW-1:0]          r_ptr;
    logic [IDW-1:0]          r_gid;
    logic [N_REQ-1:0]        r_gnt_oh;
    logic [3:0]              r_burst;
    logic [7:0]              r_idle;
    logic [7:0]              r_drop;
    logic [NET_FLIT_W-1:0]   r_net_data;
    logic                    r_net_valid;

    logic [N_REQ-1:0]        w_pick_gnt;
    logic [IDW-1:0]          w_pick_idx;
    logic                    w_pick_any;
    logic                    w_out_free;
    logic                    w_gnt_valid;
    logic                    w_accept;
    logic                    w_self;
    logic [NET_FLIT_W-1:0]   w_flit;
    logic [4:0]              w_burst_nxt;
    logic [8:0]              w_idle_nxt;
    logic                    w_grant_end;

    rr_pick #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_pick_gnt),
        .idx     (w_pick_idx),
        .any_req (w_pick_any)
    );

    // Output slot can take a new flit if empty or draining this cycle.
    assign w_out_free  = !r_net_valid || net_ready_in;
    assign w_gnt_valid = |(req_valid & r_gnt_oh);
    assign w_accept    = |(req_valid & req_ready);
    assign w_flit      = req_data[int'(r_gid)*NET_FLIT_W +: NET_FLIT_W];
    assign w_self      = (flit_dest(w_flit) == c_self_id);
    assign w_burst_nxt = {1'b0, r_burst} + 5'd1;
    assign w_idle_nxt  = {1'b0, r_idle} + 9'd1;

    // Last flit and burst limit on the same acceptance collapse to one end.
    assign w_grant_end = (w_accept && (req_last[r_gid] || (w_burst_nxt >= c_max_burst)))
                       || ((r_state == ARB_GRANT) && !w_gnt_valid && (w_idle_nxt >= c_idle_timeout));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_fsm_comb
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                req_ready = r_gnt_oh & {N_REQ{w_out_free}};
                if (w_grant_end) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Grant context: owner, rotation pointer, burst and idle counters.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_gid    <= '0;
            r_gnt_oh <= '0;
            r_ptr    <= '0;
            r_burst  <= '0;
            r_idle   <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_pick_any) begin
                r_gid    <= w_pick_idx;
                r_gnt_oh <= w_pick_gnt;
                r_burst  <= '0;
                r_idle   <= '0;
            end
        end else begin
            if (w_accept) begin
                r_burst <= w_burst_nxt[3:0];
                r_idle  <= '0;
            end else if (!w_gnt_valid) begin
                // Backpressured-but-valid cycles do not count as idle.
                r_idle  <= w_idle_nxt[7:0];
            end
            if (w_grant_end) begin
                r_ptr <= (r_gid == IDW'(N_REQ - 1)) ? '0 : r_gid + 1'b1;
            end
        end
    end

    // Registered NI stage; self-addressed flits never enter it.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_net_data  <= '0;
            r_net_valid <= 1'b0;
        end else if (w_accept && !w_self) begin
            r_net_data  <= w_flit;
            r_net_valid <= 1'b1;
        end else if (net_ready_in) begin
            r_net_valid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_drop <= '0;
        end else if (w_accept && w_self && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign net_data_out  = r_net_data;
    assign net_valid_out = r_net_valid;
    assign grant_id      = r_gid;
    assign busy          = (r_state == ARB_GRANT);
    assign self_drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_net_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_net_tx_arbiter
//  Description : Self-checking bench for net_tx_arbiter. Per-requester flit
//                queues feed a protocol-obeying driver; directed scenarios
//                check latency, rotation, burst limit, timeout, self-drop,
//                backpressure and reset; a randomized phase checks every
//                forwarded flit against per-source expected streams.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_net_tx_arbiter;

    localparam int N = 4;

    logic            ACLK;
    logic            ARESET;
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [15:0]     net_data_out;
    logic            net_valid_out;
    logic            net_ready_in;
    logic [1:0]      grant_id;
    logic            busy;
    logic [7:0]      self_drop_cnt;

    net_tx_arbiter #(
        .N_REQ        (N),
        .GPU_ID       (16),
        .MAX_BURST    (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .net_data_out  (net_data_out),
        .net_valid_out (net_valid_out),
        .net_ready_in  (net_ready_in),
        .grant_id      (grant_id),
        .busy          (busy),
        .self_drop_cnt (self_drop_cnt)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int          vectors = 0;
    int          errs    = 0;

    // Stimulus queues ({last, flit}) and expected forwarded streams.
    logic [16:0] txbuf  [N][512];
    int          wr     [N];
    int          rd     [N];
    logic [15:0] expbuf [N][64];
    int          ewr    [N];
    int          erd    [N];
    int          nself;

    logic [N-1:0] en;
    bit           rand_gap, rand_rdy, rdy_val, sb_on;

    // Samples taken at the falling edge of the most recent cycle().
    logic         s_valid, s_busy;
    logic [15:0]  s_data;
    logic [1:0]   s_gid;
    logic [N-1:0] s_ready, s_acc;
    logic         p_valid, p_rdy, p_busy;
    logic [15:0]  p_data;

    int           gnt_log[$];
    logic [15:0]  out_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] f, input logic l);
        txbuf[k][wr[k]] = {l, f};
        wr[k]++;
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            wr[k] = 0; rd[k] = 0; ewr[k] = 0; erd[k] = 0;
        end
        nself = 0;
        req_valid = '0; req_last = '0; req_data = '0;
        gnt_log.delete();
        out_log.delete();
        p_valid = 1'b0; p_rdy = 1'b0; p_busy = 1'b0; p_data = '0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        clear_all();
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
    endtask

    // One clock: observe at negedge, then drive just after posedge.
    task automatic cycle();
        int sk;
        @(negedge ACLK);
        s_valid = net_valid_out; s_busy = busy; s_data = net_data_out;
        s_gid = grant_id; s_ready = req_ready;
        s_acc = req_valid & req_ready;
        chk("ready_onehot", ($countones(req_ready) <= 1), 1);
        if (req_ready != '0) chk("ready_when_busy", busy, 1);
        if (p_valid && !p_rdy) begin
            chk("stall_valid", net_valid_out, 1);
            chk("stall_data", net_data_out, p_data);
        end
        p_valid = net_valid_out; p_rdy = net_ready_in; p_data = net_data_out;
        if (busy && !p_busy) gnt_log.push_back(int'(grant_id));
        p_busy = busy;
        if (net_valid_out && net_ready_in) begin
            out_log.push_back(net_data_out);
            if (sb_on) begin
                sk = int'(net_data_out[9:8]);
                if (erd[sk] < ewr[sk]) begin
                    chk("sb_flit", net_data_out, expbuf[sk][erd[sk]]);
                    erd[sk]++;
                end else begin
                    chk("sb_extra_flit", erd[sk], ewr[sk] + 1);
                end
            end
        end
        for (int k = 0; k < N; k++) if (s_acc[k]) rd[k]++;
        @(posedge ACLK);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!(req_valid[k] && !s_acc[k])) begin
                req_valid[k] = en[k] && (rd[k] != wr[k]) && (!rand_gap || $urandom_range(3) != 0);
                if (req_valid[k]) {req_last[k], req_data[16*k +: 16]} = txbuf[k][rd[k]];
            end
        end
        net_ready_in = rand_rdy ? ($urandom_range(3) != 0) : rdy_val;
    endtask

    task automatic run_until_idle(input int max, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            cycle();
            done = (req_valid == '0) && !busy && !net_valid_out;
            for (int k = 0; k < N; k++) if (rd[k] != wr[k]) done = 1'b0;
        end
        chk(tag, done, 1);
    endtask

    initial begin : main
        logic [15:0] exp3 [7];
        logic [5:0]  d;
        logic [15:0] f;
        int          n;

        en = '0; rand_gap = 0; rand_rdy = 0; rdy_val = 1; sb_on = 0;
        net_ready_in = 1'b1;
        do_reset();

        // Reset state
        chk("rst_valid", net_valid_out, 0);
        chk("rst_data", net_data_out, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", self_drop_cnt, 0);

        // Single flit from requester 1: grant after 1 edge, output after 2
        en = 4'b0010;
        push(1, 16'h4ABC, 1'b1);
        cycle();
        cycle();
        chk("t1_busy0", s_busy, 0);
        chk("t1_valid0", s_valid, 0);
        cycle();
        chk("t1_busy1", s_busy, 1);
        chk("t1_gid", s_gid, 1);
        chk("t1_ready", s_ready, 4'b0010);
        chk("t1_valid1", s_valid, 0);
        cycle();
        chk("t1_out_valid", s_valid, 1);
        chk("t1_out_data", s_data, 16'h4ABC);
        chk("t1_busy_end", s_busy, 0);
        cycle();
        chk("t1_valid_1cyc", s_valid, 0);
        // Pointer now at 2: between requesters 0 and 3, 3 wins
        gnt_log.delete();
        push(0, 16'h0411, 1'b1);
        push(3, 16'h0C11, 1'b1);
        en = 4'b1001;
        run_until_idle(30, "t1_drain");
        chk("t1_ngrant", gnt_log.size(), 2);
        if (gnt_log.size() >= 2) begin
            chk("t1_rr_first", gnt_log[0], 3);
            chk("t1_rr_second", gnt_log[1], 0);
        end

        // All four requesters with back-to-back 1-flit messages
        do_reset();
        en = '1;
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < N; k++) push(k, 16'h0800 | 16'(k * 16 + m), 1'b1);
        run_until_idle(60, "t2_drain");
        chk("t2_ngrant", gnt_log.size(), 8);
        if (gnt_log.size() >= 8)
            for (int i = 0; i < 8; i++) chk("t2_order", gnt_log[i], i % 4);

        // Burst limit: 6-flit message from 0 is split around requester 2
        do_reset();
        en = 4'b0101;
        for (int i = 1; i <= 6; i++) push(0, 16'h0400 | 16'(i), (i == 6));
        push(2, 16'h0C20, 1'b1);
        exp3 = '{16'h0401, 16'h0402, 16'h0403, 16'h0404, 16'h0C20, 16'h0405, 16'h0406};
        run_until_idle(60, "t3_drain");
        chk("t3_ngrant", gnt_log.size(), 3);
        if (gnt_log.size() >= 3) begin
            chk("t3_g0", gnt_log[0], 0);
            chk("t3_g1", gnt_log[1], 2);
            chk("t3_g2", gnt_log[2], 0);
        end
        chk("t3_nout", out_log.size(), 7);
        if (out_log.size() >= 7)
            for (int i = 0; i < 7; i++) chk("t3_flit", out_log[i], exp3[i]);

        // Idle timeout: requester 3 stops mid-message
        do_reset();
        en = 4'b1000;
        push(3, 16'h0C31, 1'b0);
        n = 0;
        s_acc = '0;
        while (!s_acc[3] && n < 10) begin
            cycle();
            n++;
        end
        chk("t4_first_accept", s_acc[3], 1);
        push(0, 16'h0401, 1'b1);
        en = 4'b1001;
        n = 0;
        s_busy = 1'b1;
        while (s_busy && n < 40) begin
            cycle();
            n++;
        end
        chk("t4_timeout_edges", n - 1, 16);
        push(3, 16'h0C32, 1'b1);
        run_until_idle(60, "t4_drain");
        chk("t4_ngrant", gnt_log.size(), 3);
        if (gnt_log.size() >= 2) begin
            chk("t4_g0", gnt_log[0], 3);
            chk("t4_g1", gnt_log[1], 0);
        end

        // Self-addressed flits are dropped and counted, saturating at 255
        do_reset();
        en = 4'b0010;
        push(1, 16'h4123, 1'b1);
        run_until_idle(20, "t5_drain1");
        chk("t5_drop1", self_drop_cnt, 1);
        chk("t5_noout1", out_log.size(), 0);
        en = 4'b0001;
        for (int i = 0; i < 300; i++) push(0, 16'h4000 | 16'(i[9:0]), 1'b1);
        run_until_idle(1500, "t5_drain300");
        chk("t5_drop_sat", self_drop_cnt, 255);
        chk("t5_noout300", out_log.size(), 0);

        // Backpressure then asynchronous reset mid-burst
        do_reset();
        en = 4'b0100;
        rdy_val = 1'b1;
        push(2, 16'h0855, 1'b0);
        push(2, 16'h0866, 1'b0);
        push(2, 16'h0877, 1'b1);
        cycle();
        cycle();
        rdy_val = 1'b0;
        cycle();
        chk("t6_accept_x", s_acc, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t6_hold_valid", s_valid, 1);
            chk("t6_hold_data", s_data, 16'h0855);
            chk("t6_hold_ready", s_ready, 0);
            chk("t6_hold_busy", s_busy, 1);
        end
        #2 ARESET = 1'b1;
        #1;
        chk("t6_ar_valid", net_valid_out, 0);
        chk("t6_ar_data", net_data_out, 0);
        chk("t6_ar_ready", req_ready, 0);
        chk("t6_ar_gid", grant_id, 0);
        chk("t6_ar_busy", busy, 0);
        clear_all();
        rdy_val = 1'b1;
        net_ready_in = 1'b1;
        @(posedge ACLK);
        #3 ARESET = 1'b0;
        en = '1;
        for (int k = 0; k < N; k++) push(k, 16'h0900 | 16'(k), 1'b1);
        run_until_idle(40, "t6_drain");
        chk("t6_ngrant", gnt_log.size(), 4);
        if (gnt_log.size() >= 1) chk("t6_restart_g0", gnt_log[0], 0);

        // Randomized traffic against per-source expected streams
        do_reset();
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 24; i++) begin
                if ($urandom_range(3) == 0) begin
                    d = 6'd16;
                end else begin
                    d = 6'($urandom_range(63));
                    if (d == 6'd16) d = 6'd17;
                end
                f = {d, 2'(k), 8'(i)};
                push(k, f, (i == 23) || ($urandom_range(2) == 0));
                if (d == 6'd16) begin
                    nself++;
                end else begin
                    expbuf[k][ewr[k]] = f;
                    ewr[k]++;
                end
            end
        end
        sb_on = 1; rand_gap = 1; rand_rdy = 1; en = '1;
        run_until_idle(5000, "rand_drain");
        for (int k = 0; k < N; k++) chk("rand_all_out", erd[k], ewr[k]);
        chk("rand_drop", self_drop_cnt, nself);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
